// File: rtl/reg_file_mp.sv
// Multi-port register file: one write port, two combinational read ports, async clear on reset,
// optional write-through bypass, optional hard-wired zero entry and a sequential sweep-clear engine.
module reg_file_mp #(
    parameter int unsigned DW      = 8,
    parameter int unsigned AW      = 4,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] dat_in_i,
    input  logic [AW-1:0] rd_addr_a_i,
    input  logic [AW-1:0] rd_addr_b_i,
    output logic [DW-1:0] dat_a_o,
    output logic [DW-1:0] dat_b_o,
    input  logic          clr_req_i,
    output logic          busy_o
);

    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

    state_e        state_q;
    logic [AW-1:0] ptr_q;
    logic          busy_q;

    logic [DW-1:0] core_q [Depth];
    logic [DW-1:0] core_d [Depth];

    logic          wr_accept;
    logic          last_entry;

    assign wr_accept  = wr_en_i && !busy_q && !(ZERO_R0 && (wr_addr_i == '0));
    assign last_entry = (ptr_q == AW'(Depth - 1));
    assign busy_o     = busy_q;

    // A write and a sweep step never coincide: writes are refused while busy.
    always_comb begin
        core_d = core_q;
        if (wr_accept) begin
            core_d[wr_addr_i] = dat_in_i;
        end
        if (state_q == StClear) begin
            core_d[ptr_q] = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                core_q[i] <= '0;
            end
        end else begin
            core_q <= core_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (clr_req_i) begin
                        state_q <= StClear;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StClear: begin
                    if (last_entry) begin
                        state_q <= StIdle;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + AW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ptr_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    logic [1:0][AW-1:0] rd_addr;
    logic [1:0][DW-1:0] rd_data;

    assign rd_addr[0] = rd_addr_a_i;
    assign rd_addr[1] = rd_addr_b_i;
    assign dat_a_o    = rd_data[0];
    assign dat_b_o    = rd_data[1];

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        always_comb begin
            rd_data[p] = core_q[rd_addr[p]];
            if (ZERO_R0 && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
            end else if (BYPASS && wr_accept && (wr_addr_i == rd_addr[p])) begin
                rd_data[p] = dat_in_i;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (bypass / zero-r0) share stimulus and are compared
// against a behavioural array model of the register file and its sweep.
module tb_reg_file_mp;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] dat_in;
    logic [3:0] rd_a;
    logic [3:0] rd_b;
    logic       clr_req;

    logic [7:0] a_dat_a, a_dat_b, b_dat_a, b_dat_b;
    logic       a_busy, b_busy;

    int n_pass  = 0;
    int n_total = 0;

    // Model: instance a has bypass, instance b has no bypass and a hard zero entry 0.
    logic [7:0] m_a [16];
    logic [7:0] m_b [16];
    int         m_left;
    int         m_idx;

    always #5 clk = ~clk;

    reg_file_mp #(.DW(8), .AW(4), .BYPASS(1'b1), .ZERO_R0(1'b0)) u_dut_a (
        .clk_i(clk), .reset_i(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .dat_in_i(dat_in),
        .rd_addr_a_i(rd_a), .rd_addr_b_i(rd_b), .dat_a_o(a_dat_a), .dat_b_o(a_dat_b),
        .clr_req_i(clr_req), .busy_o(a_busy)
    );

    reg_file_mp #(.DW(8), .AW(4), .BYPASS(1'b0), .ZERO_R0(1'b1)) u_dut_b (
        .clk_i(clk), .reset_i(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .dat_in_i(dat_in),
        .rd_addr_a_i(rd_a), .rd_addr_b_i(rd_b), .dat_a_o(b_dat_a), .dat_b_o(b_dat_b),
        .clr_req_i(clr_req), .busy_o(b_busy)
    );

    function automatic logic [7:0] exp_rd(input int inst, input logic [3:0] addr);
        if (inst == 1) begin
            if (addr == 4'd0) return 8'h00;
            return m_b[addr];
        end
        if (wr_en && m_left == 0 && wr_addr == addr) return dat_in;
        return m_a[addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_a[i] = 8'h00;
            m_b[i] = 8'h00;
        end
        m_left = 0;
        m_idx  = 0;
    endtask

    task automatic model_edge();
        @(posedge clk);
        if (m_left > 0) begin
            m_a[m_idx] = 8'h00;
            m_b[m_idx] = 8'h00;
            m_idx++;
            m_left--;
        end else begin
            if (wr_en) begin
                m_a[wr_addr] = dat_in;
                if (wr_addr != 4'd0) m_b[wr_addr] = dat_in;
            end
            if (clr_req) begin
                m_left = 16;
                m_idx  = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        wr_en   = 1'b0;
        clr_req = 1'b0;
        wr_addr = 4'd0;
        dat_in  = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        rd_a = 4'd3;
        rd_b = 4'd9;
        model_reset();
        #3;
        n_total++;
        if (a_dat_a !== 8'h00 || a_busy !== 1'b0 || b_busy !== 1'b0)
            $display("FAIL reset_init: dat=%h busy=%b/%b want 00 0/0", a_dat_a, a_busy, b_busy);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_edge();
        wr_en = 1'b1; wr_addr = 4'd3; dat_in = 8'hA5;
        #2;
        model_edge();
        idle_inputs();
        #2;
        n_total++;
        if (a_dat_a !== 8'hA5) $display("FAIL reset_prewrite: got %h want a5", a_dat_a);
        else n_pass++;
        reset = 1'b1;
        #1;
        model_reset();
        n_total++;
        if (a_dat_a !== 8'h00 || b_dat_a !== 8'h00 || a_busy !== 1'b0)
            $display("FAIL reset_async: dat=%h/%h busy=%b want 00/00 0", a_dat_a, b_dat_a, a_busy);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_edge();
        // Reset in the middle of a sweep must drop busy at once.
        clr_req = 1'b1;
        #2;
        model_edge();
        clr_req = 1'b0;
        model_edge();
        model_edge();
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        n_total++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0)
            $display("FAIL reset_mid_sweep: busy=%b/%b want 0/0", a_busy, b_busy);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_edge();
    endtask

    task automatic test_write_read();
        rd_a = 4'd5; rd_b = 4'd5;
        wr_en = 1'b1; wr_addr = 4'd5; dat_in = 8'h3C;
        #2;
        n_total++;
        if (a_dat_a !== 8'h3C || a_dat_b !== 8'h3C)
            $display("FAIL wr_bypass: got %h/%h want 3c/3c", a_dat_a, a_dat_b);
        else n_pass++;
        n_total++;
        if (b_dat_a !== 8'h00 || b_dat_b !== 8'h00)
            $display("FAIL wr_nobypass: got %h/%h want 00/00", b_dat_a, b_dat_b);
        else n_pass++;
        model_edge();
        idle_inputs();
        #2;
        n_total++;
        if (a_dat_a !== 8'h3C || a_dat_b !== 8'h3C || b_dat_a !== 8'h3C || b_dat_b !== 8'h3C)
            $display("FAIL wr_next: got %h %h %h %h want 3c", a_dat_a, a_dat_b, b_dat_a, b_dat_b);
        else n_pass++;
        model_edge();
    endtask

    task automatic test_zero_r0();
        rd_a = 4'd0; rd_b = 4'd0;
        wr_en = 1'b1; wr_addr = 4'd0; dat_in = 8'hFF;
        #2;
        n_total++;
        if (b_dat_a !== 8'h00 || a_dat_a !== 8'hFF)
            $display("FAIL r0_write_cycle: zero=%h byp=%h want 00/ff", b_dat_a, a_dat_a);
        else n_pass++;
        model_edge();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            #2;
            n_total++;
            if (b_dat_a !== 8'h00 || b_dat_b !== 8'h00 || a_dat_a !== 8'hFF)
                $display("FAIL r0_later: zero=%h/%h plain=%h want 00/00/ff", b_dat_a, b_dat_b,
                         a_dat_a);
            else n_pass++;
            model_edge();
        end
    endtask

    task automatic test_sweep();
        int n_busy;
        n_busy = 0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); dat_in = 8'(8'h10 + i);
            #2;
            model_edge();
        end
        idle_inputs();
        clr_req = 1'b1;
        #2;
        model_edge();
        for (int k = 0; k < 40; k++) begin
            rd_a = 4'd2; rd_b = 4'd9;
            if (k == 6) begin
                wr_en = 1'b1; wr_addr = 4'd15; dat_in = 8'h77; clr_req = 1'b1;
            end else begin
                idle_inputs();
            end
            #2;
            if (k == 4) begin
                n_total++;
                if (a_dat_a !== 8'h00 || a_dat_b !== 8'h19 || b_dat_b !== 8'h19)
                    $display("FAIL sweep_mid: r2=%h r9=%h/%h want 00 19/19", a_dat_a, a_dat_b,
                             b_dat_b);
                else n_pass++;
            end
            if (a_busy !== 1'b1) break;
            n_busy++;
            model_edge();
        end
        n_total++;
        if (n_busy !== 16) $display("FAIL sweep_busy_len: got %0d cycles want 16", n_busy);
        else n_pass++;
        idle_inputs();
        model_edge();
        for (int i = 0; i < 16; i++) begin
            rd_a = 4'(i); rd_b = 4'(15 - i);
            #2;
            n_total++;
            if (a_dat_a !== 8'h00 || a_dat_b !== 8'h00 || b_dat_a !== 8'h00 || b_busy !== 1'b0)
                $display("FAIL sweep_after r%0d: got %h %h %h busy=%b want 00 0", i, a_dat_a,
                         a_dat_b, b_dat_a, b_busy);
            else n_pass++;
            model_edge();
        end
    endtask

    task automatic test_same_cycle();
        rd_a = 4'd7; rd_b = 4'd7;
        wr_en = 1'b1; wr_addr = 4'd7; dat_in = 8'h42; clr_req = 1'b1;
        #2;
        model_edge();
        idle_inputs();
        #2;
        n_total++;
        if (a_dat_a !== 8'h42 || b_dat_b !== 8'h42 || a_busy !== 1'b1)
            $display("FAIL same_cycle_write: got %h/%h busy=%b want 42/42 1", a_dat_a, b_dat_b,
                     a_busy);
        else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            model_edge();
            #2;
            n_total++;
            if (a_dat_a !== ((k < 8) ? 8'h42 : 8'h00))
                $display("FAIL same_cycle_sweep k=%0d: got %h want %h", k, a_dat_a,
                         (k < 8) ? 8'h42 : 8'h00);
            else n_pass++;
        end
        for (int k = 0; k < 20 && m_left > 0; k++) model_edge();
        #2;
        n_total++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0)
            $display("FAIL same_cycle_done: busy=%b/%b want 0/0", a_busy, b_busy);
        else n_pass++;
        model_edge();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int k = 0; k < 300; k++) begin
            wr_en   = 1'($urandom_range(0, 3) != 0);
            wr_addr = 4'($urandom_range(0, 15));
            dat_in  = 8'($urandom);
            clr_req = 1'($urandom_range(0, 39) == 0);
            rd_a    = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            rd_b    = ($urandom_range(0, 3) == 0) ? rd_a : 4'($urandom_range(0, 15));
            #2;
            n_total++;
            if (a_dat_a !== exp_rd(0, rd_a) || a_dat_b !== exp_rd(0, rd_b) ||
                b_dat_a !== exp_rd(1, rd_a) || b_dat_b !== exp_rd(1, rd_b) ||
                a_busy !== (m_left > 0) || b_busy !== (m_left > 0)) begin
                errs++;
                if (errs < 10)
                    $display("FAIL random k=%0d: got %h %h %h %h %b%b want %h %h %h %h %b", k,
                             a_dat_a, a_dat_b, b_dat_a, b_dat_b, a_busy, b_busy,
                             exp_rd(0, rd_a), exp_rd(0, rd_b), exp_rd(1, rd_a),
                             exp_rd(1, rd_b), m_left > 0);
            end else n_pass++;
            model_edge();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_r0();
        test_sweep();
        test_same_cycle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
